// File: rtl/fft_r2_sched.sv
// fft_r2_sched
// Address sequencer for an in-place radix-2 decimation-in-time FFT.
// Walks LOG2N stages of N/2 butterflies. Each butterfly issues the operand
// read addresses and the twiddle index. One clock later it issues the
// matching write-back addresses. The butterfly between them is
// combinational, and the RAM and ROM have one-cycle synchronous reads.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a transform (sampled in IDLE only)
//   stall      hold butterfly issue while high (RUN only)
//   busy       high from accepted start until done
//   done       one-cycle completion pulse
//   stage      current stage index s (0 in IDLE)
//   rd_en      sample RAM read strobe, both ports
//   rd_addr_a  operand A read address
//   rd_addr_b  operand B read address
//   tw_addr    twiddle ROM index k, W = W_N^k
//   wr_en      sample RAM write strobe, both ports
//   wr_addr_a  write address for A+WB
//   wr_addr_b  write address for A-WB
module fft_r2_sched #(
    parameter int LOG2N = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic [4:0]       stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b
);

    localparam int BW = LOG2N - 1;
    localparam logic [BW-1:0] B_LAST = '1;
    localparam logic [BW-1:0] B_ONE  = BW'(1);
    localparam logic [4:0]    S_LAST = 5'(LOG2N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [4:0]       r_s;
    logic [BW-1:0]    r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_rd_en;
    logic [LOG2N-1:0] r_rd_a;
    logic [LOG2N-1:0] r_rd_b;
    logic [BW-1:0]    r_tw;
    logic             r_wr_en;
    logic [LOG2N-1:0] r_wr_a;
    logic [LOG2N-1:0] r_wr_b;

    logic [BW-1:0]    w_jmask;
    logic [BW-1:0]    w_j;
    logic [BW-1:0]    w_k;
    logic [LOG2N-1:0] w_half;
    logic [LOG2N-1:0] w_addr_a;
    logic [LOG2N-1:0] w_addr_b;

    // Butterfly b of stage s: the group index (b>>s) selects a block of
    // 2*half samples, and j is the offset inside the lower half of it.
    assign w_jmask  = ~({BW{1'b1}} << r_s);
    assign w_j      = r_b & w_jmask;
    assign w_k      = w_j << (S_LAST - r_s);
    assign w_half   = LOG2N'(1) << r_s;
    assign w_addr_a = (({1'b0, r_b} >> r_s) << (r_s + 5'd1)) | {1'b0, w_j};
    assign w_addr_b = w_addr_a + w_half;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_b     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_tw    <= '0;
            r_wr_en <= 1'b0;
            r_wr_a  <= '0;
            r_wr_b  <= '0;
        end else begin
            // Write-back stage: the butterfly result for the read issued on
            // the previous edge returns to the same two addresses.
            r_wr_en <= r_rd_en;
            r_wr_a  <= r_rd_a;
            r_wr_b  <= r_rd_b;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;

            // Issue stage.
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_s     <= '0;
                        r_b     <= '0;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        r_rd_en <= 1'b1;
                        r_rd_a  <= w_addr_a;
                        r_rd_b  <= w_addr_b;
                        r_tw    <= w_k;
                        r_b     <= r_b + B_ONE;
                        if (r_b == B_LAST) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // One idle issue slot. The last write of this stage lands
                    // on this edge, so the next stage's first read comes after it.
                    if (r_s == S_LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                        r_s     <= r_s + 5'd1;
                        r_b     <= '0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_s     <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign stage     = r_s;
    assign rd_en     = r_rd_en;
    assign rd_addr_a = r_rd_a;
    assign rd_addr_b = r_rd_b;
    assign tw_addr   = r_tw;
    assign wr_en     = r_wr_en;
    assign wr_addr_a = r_wr_a;
    assign wr_addr_b = r_wr_b;

endmodule
